// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 types, timing defaults and command bytes.
// Used by the host transmitter and the keyboard receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SHIFT,
    S_WAIT_IDLE,
    S_FAIL
  } tx_state_t;

  localparam int unsigned PS2_CLK_HZ         = 50_000_000;
  localparam int unsigned PS2_INHIBIT_CYC    = 5000;
  localparam int unsigned PS2_FIRST_EDGE_CYC = 750_000;
  localparam int unsigned PS2_PACKET_CYC     = 100_000;
  localparam int unsigned PS2_TMR_W          = 20;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizer for PS/2 clock and data lines
// with a registered falling-edge strobe on the clock line.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic clk_sync,
  output logic dat_sync,
  output logic fe
);

  logic clk_meta;
  logic dat_meta;
  logic clk_prev;

  // Idle lines are pulled high, so the chain resets to 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      clk_prev <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
      fe       <= 1'b0;
    end else begin
      clk_meta <= ps2_clk;
      clk_sync <= clk_meta;
      clk_prev <= clk_sync;
      dat_meta <= ps2_dat;
      dat_sync <= dat_meta;
      fe       <= clk_prev & ~clk_sync;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command byte transmitter.
// Define PS2_TX_RETRY_EN to retry a failed frame twice before error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ         = PS2_CLK_HZ,
  parameter int unsigned INHIBIT_CYC    = PS2_INHIBIT_CYC,
  parameter int unsigned FIRST_EDGE_CYC = PS2_FIRST_EDGE_CYC,
  parameter int unsigned PACKET_CYC     = PS2_PACKET_CYC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       done,
  output logic       error,
  output logic       rx_inhibit
);

  localparam logic [PS2_TMR_W-1:0] INH_LAST =
    PS2_TMR_W'(INHIBIT_CYC - 1);
  localparam logic [PS2_TMR_W-1:0] FE_LAST =
    PS2_TMR_W'(FIRST_EDGE_CYC - 2);
  localparam logic [PS2_TMR_W-1:0] PKT_LAST =
    PS2_TMR_W'(PACKET_CYC - 2);

  logic clk_hz_unused;
  assign clk_hz_unused = (CLK_HZ == 0);

  tx_state_t            state;
  logic [7:0]           data;
  logic                 par;
  logic [3:0]           n;
  logic [PS2_TMR_W-1:0] tmr;
  logic [PS2_TMR_W-1:0] pkt;
  logic                 clk_sync;
  logic                 dat_sync;
  logic                 fe;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]           retry;
`endif

  ps2_line_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk_i),
    .ps2_dat  (ps2_dat_i),
    .clk_sync (clk_sync),
    .dat_sync (dat_sync),
    .fe       (fe)
  );

  // Timeouts are one cycle short of the limit because FAIL
  // adds a cycle before the error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_ready   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      rx_inhibit <= 1'b0;
      data       <= '0;
      par        <= 1'b0;
      n          <= '0;
      tmr        <= '0;
      pkt        <= '0;
`ifdef PS2_TX_RETRY_EN
      retry      <= '0;
`endif
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      tmr   <= (&tmr) ? tmr : tmr + 1'b1;
      pkt   <= (&pkt) ? pkt : pkt + 1'b1;
      unique case (state)
        S_IDLE: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          rx_inhibit <= 1'b0;
          tx_ready   <= 1'b1;
          if (tx_valid && tx_ready) begin
            data       <= tx_data;
            par        <= odd_parity(tx_data);
            n          <= '0;
            tmr        <= '0;
`ifdef PS2_TX_RETRY_EN
            retry      <= '0;
`endif
            tx_ready   <= 1'b0;
            rx_inhibit <= 1'b1;
            ps2_clk_oe <= 1'b1;
            state      <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (tmr == INH_LAST) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b1;
            tmr        <= '0;
            state      <= S_START;
          end
        end
        S_START: begin
          if (fe) begin
            n          <= 4'd1;
            pkt        <= '0;
            ps2_dat_oe <= ~data[0];
            state      <= S_SHIFT;
          end else if (tmr == FE_LAST) begin
            ps2_dat_oe <= 1'b0;
            state      <= S_FAIL;
          end
        end
        S_SHIFT: begin
          if (pkt == PKT_LAST) begin
            ps2_dat_oe <= 1'b0;
            state      <= S_FAIL;
          end else if (fe) begin
            n <= n + 4'd1;
            unique case (1'b1)
              (n <= 4'd7): ps2_dat_oe <= ~data[n[2:0]];
              (n == 4'd8): ps2_dat_oe <= ~par;
              (n == 4'd9): ps2_dat_oe <= 1'b0;
              default:
                state <= dat_sync ? S_FAIL : S_WAIT_IDLE;
            endcase
          end
        end
        S_WAIT_IDLE: begin
          if (clk_sync && dat_sync) begin
            done       <= 1'b1;
            rx_inhibit <= 1'b0;
            state      <= S_IDLE;
          end else if (pkt == PKT_LAST) begin
            state <= S_FAIL;
          end
        end
        S_FAIL: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
          if (retry < 2'd2) begin
            retry      <= retry + 2'd1;
            tmr        <= '0;
            ps2_clk_oe <= 1'b1;
            state      <= S_INHIBIT;
          end else begin
            error      <= 1'b1;
            rx_inhibit <= 1'b0;
            state      <= S_IDLE;
          end
`else
          error      <= 1'b1;
          rx_inhibit <= 1'b0;
          state      <= S_IDLE;
`endif
        end
        default: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          rx_inhibit <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed scoreboard bench for ps2_host_tx with
// a bit-level PS/2 device model on the open-collector lines.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 50;
  localparam int FEC  = 400;
  localparam int PKT  = 2000;
  localparam int HALF = 15;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  localparam logic [1:0] R_DONE = 2'b01;
  localparam logic [1:0] R_ERR  = 2'b10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk_i;
  logic       ps2_dat_i;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       done;
  logic       error;
  logic       rx_inhibit;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int res_cnt = 0;
  bit chk_ready = 1'b0;

  logic [1:0]  res_q[$];
  logic [10:0] frame_q[$];

  typedef struct {
    logic [7:0] d;
    logic       p;
  } vec_t;

  vec_t vecs[4];

  assign ps2_clk_i = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_i = ~(ps2_dat_oe | dev_dat_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_HZ         (50_000_000),
    .INHIBIT_CYC    (INH),
    .FIRST_EDGE_CYC (FEC),
    .PACKET_CYC     (PKT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_dat_i  (ps2_dat_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .done       (done),
    .error      (error),
    .rx_inhibit (rx_inhibit)
  );

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result monitor: pops the scoreboard on every done/error pulse.
  always @(negedge clk) begin
    logic [1:0] got;
    if (chk_ready) begin
      check("tx_ready after result", {31'd0, tx_ready}, 1);
      chk_ready = 1'b0;
    end
    if (done || error) begin
      got = {error, done};
      if (res_q.size() == 0)
        check("unexpected result", {30'd0, got}, 0);
      else
        check("result", {30'd0, got}, {30'd0, res_q.pop_front()});
      check("lines at result",
            {28'd0, ps2_clk_oe, ps2_dat_oe, rx_inhibit, tx_ready}, 0);
      chk_ready = 1'b1;
      res_cnt++;
    end
  end

  task automatic send(input logic [7:0] b, input bit meas_inh);
    int w = 0;
    int cnt = 0;
    while (!tx_ready && w < 200) begin
      tick();
      w++;
    end
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check("accept+1 outputs",
          {28'd0, ps2_clk_oe, ps2_dat_oe, rx_inhibit, tx_ready}, 4'b1010);
    if (meas_inh) begin
      while (ps2_clk_oe && cnt < 1000) begin
        cnt++;
        tick();
      end
      check("inhibit length", cnt, INH);
    end
  endtask

  task automatic wait_rts();
    int w = 0;
    while (!(ps2_dat_oe && !ps2_clk_oe) && w < 2000) begin
      tick();
      w++;
    end
    check("rts lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 2'b01);
  endtask

  // Device: reads start before the first clock, then one bit per
  // rising edge; optionally drives the ACK for clock 11.
  task automatic device_frame(input bit ack);
    logic [10:0] got;
    wait_rts();
    repeat (10) tick();
    got[0] = ps2_dat_i;
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) tick();
      dev_clk_low = 1'b0;
      got[i] = ps2_dat_i;
      if (i == 10) begin
        repeat (7) tick();
        dev_dat_low = ack;
        repeat (8) tick();
      end else begin
        repeat (HALF) tick();
      end
    end
    dev_clk_low = 1'b1;
    repeat (HALF) tick();
    dev_clk_low = 1'b0;
    repeat (3) tick();
    dev_dat_low = 1'b0;
    if (frame_q.size() == 0)
      check("unexpected frame", {21'd0, got}, 0);
    else
      check("frame", {21'd0, got}, {21'd0, frame_q.pop_front()});
  endtask

  task automatic wait_result(input int target);
    int w = 0;
    while (res_cnt < target && w < 4000) begin
      tick();
      w++;
    end
    check("result count", res_cnt, target);
    repeat (3) tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int cnt;
    int w;
    vecs[0] = '{PS2_CMD_SET_LEDS, 1'b1};
    vecs[1] = '{8'h01, 1'b0};
    vecs[2] = '{PS2_CMD_RESET, 1'b1};
    vecs[3] = '{PS2_ACK, 1'b1};

    repeat (3) tick();
    check("reset outputs",
          {26'd0, ps2_clk_oe, ps2_dat_oe, tx_ready, done, error, rx_inhibit},
          6'b001000);
    reset = 1'b1;
    tick();
    check("ready after reset", {31'd0, tx_ready}, 1);

    // ACKed frames: data, hand-computed odd parity, stop
    foreach (vecs[k]) begin
      base = res_cnt;
      frame_q.push_back({1'b1, vecs[k].p, vecs[k].d, 1'b0});
      res_q.push_back(R_DONE);
      send(vecs[k].d, 1'b1);
      device_frame(1'b1);
      wait_result(base + 1);
    end

    // Device never clocks
    base = res_cnt;
    res_q.push_back(R_ERR);
    send(8'h55, 1'b0);
    for (int a = 0; a < ATTEMPTS; a++) begin
      w = 0;
      while (!ps2_dat_oe && w < 1000) begin
        tick();
        w++;
      end
      cnt = 0;
      while (ps2_dat_oe && cnt < FEC + 10) begin
        tick();
        cnt++;
      end
      check("start window", cnt, FEC - 1);
    end
    tick();
    check("no-clock error at FEC",
          {29'd0, error, ps2_clk_oe, ps2_dat_oe}, 3'b100);
    wait_result(base + 1);

    // Missing ACK
    base = res_cnt;
    for (int a = 0; a < ATTEMPTS; a++)
      frame_q.push_back({1'b1, 1'b1, PS2_CMD_RESET, 1'b0});
    res_q.push_back(R_ERR);
    send(PS2_CMD_RESET, 1'b0);
    for (int a = 0; a < ATTEMPTS; a++)
      device_frame(1'b0);
    wait_result(base + 1);

`ifdef PS2_TX_RETRY_EN
    base = res_cnt;
    frame_q.push_back({1'b1, 1'b0, 8'h01, 1'b0});
    frame_q.push_back({1'b1, 1'b0, 8'h01, 1'b0});
    res_q.push_back(R_DONE);
    send(8'h01, 1'b0);
    device_frame(1'b0);
    device_frame(1'b1);
    wait_result(base + 1);
`endif

    // Reset in SHIFT at n = 5 (bit4 of 8'h0F drives data low)
    send(8'h0F, 1'b0);
    wait_rts();
    repeat (10) tick();
    for (int i = 1; i <= 5; i++) begin
      dev_clk_low = 1'b1;
      if (i < 5) begin
        repeat (HALF) tick();
        dev_clk_low = 1'b0;
        repeat (HALF) tick();
      end
    end
    repeat (6) tick();
    check("oe at n=5", {30'd0, ps2_clk_oe, ps2_dat_oe}, 2'b01);
    #2;
    reset = 1'b0;
    #1;
    check("async reset lines",
          {29'd0, ps2_clk_oe, ps2_dat_oe, rx_inhibit}, 3'b000);
    dev_clk_low = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("ready after mid reset", {31'd0, tx_ready}, 1);
    base = res_cnt;
    frame_q.push_back({1'b1, 1'b1, 8'h0F, 1'b0});
    res_q.push_back(R_DONE);
    send(8'h0F, 1'b1);
    device_frame(1'b1);
    wait_result(base + 1);

    // tx_valid held, tx_data changes mid-frame
    base = res_cnt;
    frame_q.push_back({1'b1, 1'b1, 8'hA5, 1'b0});
    frame_q.push_back({1'b1, 1'b0, 8'h3D, 1'b0});
    res_q.push_back(R_DONE);
    res_q.push_back(R_DONE);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tick();
    check("held accept", {30'd0, ps2_clk_oe, tx_ready}, 2'b10);
    repeat (5) tick();
    tx_data = 8'h3D;
    device_frame(1'b1);
    check("no accept before done", {31'd0, tx_ready}, 0);
    w = 0;
    while (res_cnt < base + 1 && w < 4000) begin
      tick();
      w++;
    end
    w = 0;
    while (!ps2_clk_oe && w < 100) begin
      tick();
      w++;
    end
    tx_valid = 1'b0;
    check("second accept", {30'd0, ps2_clk_oe, rx_inhibit}, 2'b11);
    device_frame(1'b1);
    wait_result(base + 2);

    repeat (20) tick();
    check("result queue drained", res_q.size(), 0);
    check("frame queue drained", frame_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
